// File: rtl/mcpu_progmem.sv
// Program/data memory for the 6-bit accumulator CPU, with a byte-handshake
// loader that holds the CPU in reset and a debug dump stream.
module mcpu_progmem #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we_n,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rst_n,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          dump_req,
  output logic          dump_valid,
  output logic [DW-1:0] dump_data,
  input  logic          dump_ready,
  output logic          load_done
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DUMP = 2'b10;

  logic [DW-1:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          load_done_q, load_done_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Next-state, pointer and memory write-port selection
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = ld_data;

    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = AW'(ptr_q + 1'b1);
          if (ptr_q == PTR_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cpu_we_n) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_addr;
          mem_wdata = cpu_wdata;
        end
        if (dump_req) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          ptr_d = AW'(ptr_q + 1'b1);
          if (ptr_q == PTR_LAST) state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
        ptr_d   = '0;
      end
    endcase

    // No memory commits while the block is held in reset
    if (!rst) mem_we = 1'b0;

    cpu_rst_n_d = (state_d == ST_RUN);
    load_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      ptr_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      load_done_q <= load_done_d;
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign cpu_rdata  = mem_q[cpu_addr];
  assign dump_data  = mem_q[ptr_q];
  assign dump_valid = (state_q == ST_DUMP);
  assign ld_ready   = (state_q == ST_LOAD);
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_mcpu_progmem.sv
// Directed bench for mcpu_progmem; dump words are checked by a queue-driven
// monitor independent of the stimulus thread.
module tb_mcpu_progmem;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cpu_addr;
  logic [5:0] cpu_wdata;
  logic       cpu_we_n;
  logic [5:0] cpu_rdata;
  logic       cpu_rst_n;
  logic       ld_valid;
  logic [5:0] ld_data;
  logic       ld_ready;
  logic       dump_req;
  logic       dump_valid;
  logic [5:0] dump_data;
  logic       dump_ready;
  logic       load_done;

  int checks = 0;
  int errors = 0;

  logic [5:0] dump_q[$];

  mcpu_progmem dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we_n   (cpu_we_n),
    .cpu_rdata  (cpu_rdata),
    .cpu_rst_n  (cpu_rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    cpu_addr = a;
    #1;
    check(name, 8'(cpu_rdata), exp);
  endtask

  // Dump scoreboard: every presented word must match the queue head
  always @(negedge clk) begin
    if (dump_valid) begin
      check("dump_cpu_rst_n", 8'(cpu_rst_n), 8'h00);
      if (dump_q.size() == 0) begin
        check("dump_extra_word", 8'(dump_data), 8'hFF);
      end else begin
        check("dump_data", 8'(dump_data), 8'(dump_q[0]));
        if (dump_ready) void'(dump_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we_n = 1'b1;
    ld_valid = 1'b0; ld_data = '0; dump_req = 1'b0; dump_ready = 1'b0;
    tick();
    check("rst_ld_ready",   8'(ld_ready),   8'h01);
    check("rst_cpu_rst_n",  8'(cpu_rst_n),  8'h00);
    check("rst_load_done",  8'(load_done),  8'h00);
    check("rst_dump_valid", 8'(dump_valid), 8'h00);
    tick();
    rst = 1'b1;

    // Full load 0x00..0x0F with ld_valid held
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = 6'(i);
      #1;
      check("load_ld_ready", 8'(ld_ready), 8'h01);
      if (i == 15) check("pre_last_load_done", 8'(load_done), 8'h00);
      tick();
    end
    ld_valid = 1'b0;
    check("run_load_done", 8'(load_done), 8'h01);
    check("run_cpu_rst_n", 8'(cpu_rst_n), 8'h01);
    check("run_ld_ready",  8'(ld_ready),  8'h00);
    read_check("rd_addr5", 4'd5, 8'h05);

    // Store to addr 3: old word same cycle, new word next cycle
    cpu_addr = 4'd3; cpu_wdata = 6'h3F; cpu_we_n = 1'b0;
    #1;
    check("rdw_old", 8'(cpu_rdata), 8'h03);
    tick();
    cpu_we_n = 1'b1;
    #1;
    check("rdw_new", 8'(cpu_rdata), 8'h3F);
    cpu_addr = 4'd4; cpu_wdata = 6'h20;
    tick();
    check("no_write_we_n_hi", 8'(cpu_rdata), 8'h04);

    // Loader traffic in RUN is ignored
    ld_valid = 1'b1; ld_data = 6'h11;
    tick(); tick();
    ld_valid = 1'b0;
    read_check("run_ld_ign0", 4'd0, 8'h00);
    read_check("run_ld_ign1", 4'd1, 8'h01);

    // Dump request with a coincident store to addr 7
    for (int i = 0; i < 16; i++) dump_q.push_back(6'(i));
    dump_q[3] = 6'h3F;
    dump_q[7] = 6'h2E;
    dump_req = 1'b1; cpu_addr = 4'd7; cpu_wdata = 6'h2E; cpu_we_n = 1'b0;
    tick();
    dump_req = 1'b0; cpu_we_n = 1'b1;
    check("dump_entry_valid",     8'(dump_valid), 8'h01);
    check("dump_entry_load_done", 8'(load_done),  8'h00);
    for (int c = 0; c < 100 && dump_valid; c++) begin
      dump_ready = c[0];
      tick();
    end
    dump_ready = 1'b0;
    check("dump_finished",   8'(dump_valid),    8'h00);
    check("dump_q_drained",  8'(dump_q.size()), 8'h00);
    check("post_dump_ready", 8'(ld_ready),      8'h01);
    check("post_dump_rst_n", 8'(cpu_rst_n),     8'h00);

    // CPU store attempt in LOAD is ignored
    cpu_addr = 4'd2; cpu_wdata = 6'h33; cpu_we_n = 1'b0;
    tick();
    cpu_we_n = 1'b1;
    read_check("load_we_ign", 4'd2, 8'h02);

    // Loader with an idle gap
    ld_valid = 1'b1; ld_data = 6'h2A; tick();
    ld_valid = 1'b0; ld_data = 6'h01; tick();
    ld_valid = 1'b1; ld_data = 6'h15; tick();
    ld_valid = 1'b0;
    read_check("gap_mem0", 4'd0, 8'h2A);
    read_check("gap_mem1", 4'd1, 8'h15);

    // Five more words (seven total), then reset mid-load
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 6'(8'h30 + i);
      tick();
    end
    ld_valid = 1'b0;
    read_check("partial_mem6", 4'd6, 8'h34);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_ld_ready",  8'(ld_ready),  8'h01);
    check("midrst_load_done", 8'(load_done), 8'h00);

    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = 6'(8'h20 + i);
      tick();
      if (i == 0) begin
        read_check("reload_first_addr0", 4'd0, 8'h20);
        read_check("reload_kept_addr1",  4'd1, 8'h15);
      end
    end
    ld_valid = 1'b0;
    check("reload_load_done", 8'(load_done), 8'h01);
    read_check("reload_mem0",  4'd0,  8'h20);
    read_check("reload_mem6",  4'd6,  8'h26);
    read_check("reload_mem15", 4'd15, 8'h2F);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
